// File: rtl/fc_output_collector.sv
// rtl/fc_output_collector.sv - packs a class-score byte stream into a stable result vector
// Arg-max class reporting is built only when FC_OUTPUT_ARGMAX_EN is defined.
module fc_output_collector #(
  parameter int DATA_W         = 8,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [DATA_W*NUM_CLASSES-1:0] dout,
  output logic                          dout_valid,
  output logic                          frame_err,
  output logic                          busy,
  output logic [15:0]                   good_frames,
  output logic [3:0]                    class_idx
);

  localparam int CNT_W = 4;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_CLASSES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_ERR} state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_ready;
  logic [CNT_W-1:0]              r_cnt;
  logic [TMO_W-1:0]              r_tmo;
  logic [DATA_W-1:0]             r_shadow [NUM_CLASSES];
  logic [DATA_W*NUM_CLASSES-1:0] r_dout;
  logic [DATA_W*NUM_CLASSES-1:0] w_packed;
  logic                          r_dout_valid;
  logic [15:0]                   r_good;
  logic                          w_beat;
  logic                          w_busy;
  logic                          w_frame_err;

  assign w_beat = s_valid & r_ready;

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_beat) w_next = s_last ? S_ERR : S_COLLECT;
      end
      S_COLLECT: begin
        w_busy = 1'b1;
        if (w_beat) begin
          if (r_cnt == LAST_IDX) w_next = s_last ? S_DONE : S_ERR;
          else if (s_last)       w_next = S_ERR;
        end else if (r_tmo == TMO_LIMIT) begin
          w_next = S_ERR;
        end
      end
      S_DONE: w_next = S_IDLE;
      S_ERR: begin
        w_frame_err = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Slot 0 lands in the most significant byte.
  always_comb begin
    w_packed = '0;
    for (int k = 0; k < NUM_CLASSES; k++)
      w_packed[(NUM_CLASSES-1-k)*DATA_W +: DATA_W] = r_shadow[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_good       <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) r_shadow[k] <= '0;
    end else begin
      r_state      <= w_next;
      r_ready      <= (w_next == S_IDLE) || (w_next == S_COLLECT);
      r_dout_valid <= 1'b0;

      if (w_next == S_COLLECT) begin
        if (w_beat) r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end

      if (r_state == S_COLLECT && !w_beat) r_tmo <= r_tmo + TMO_W'(1);
      else                                 r_tmo <= '0;

      if (r_state == S_ERR) begin
        for (int k = 0; k < NUM_CLASSES; k++) r_shadow[k] <= '0;
      end else if (w_beat) begin
        r_shadow[r_cnt] <= s_data;
      end

      if (r_state == S_DONE) begin
        r_dout       <= w_packed;
        r_dout_valid <= 1'b1;
        if (r_good != 16'hFFFF) r_good <= r_good + 16'd1;
      end
    end
  end

`ifdef FC_OUTPUT_ARGMAX_EN
  logic signed [DATA_W-1:0] r_max;
  logic [CNT_W-1:0]         r_max_idx;
  logic [3:0]               r_class_idx;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max       <= '0;
      r_max_idx   <= '0;
      r_class_idx <= 4'hF;
    end else begin
      if (r_state == S_ERR) begin
        r_max     <= '0;
        r_max_idx <= '0;
      end else if (w_beat && (r_cnt == '0 || $signed(s_data) > r_max)) begin
        r_max     <= $signed(s_data);
        r_max_idx <= r_cnt;
      end
      if (r_state == S_DONE) r_class_idx <= r_max_idx;
    end
  end

  assign class_idx = r_class_idx;
`else
  assign class_idx = 4'hF;
`endif

  assign s_ready     = r_ready;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign frame_err   = w_frame_err;
  assign busy        = w_busy;
  assign good_frames = r_good;

endmodule
